// File: rtl/fold_sig_compare_pkg.sv
// Shared types, defaults and the rotate helper for the fold signature compare block.
package fold_sig_pkg;

  localparam int W_DEF         = 8;
  localparam int FRAME_LEN_DEF = 16;
  localparam int ROT_MAX_W     = 64;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // 1-bit left rotate of the low w bits of v; callers zero-extend into ROT_MAX_W.
  function automatic logic [ROT_MAX_W-1:0] rotl1(input logic [ROT_MAX_W-1:0] v, input int w);
    logic [ROT_MAX_W-1:0] mask;
    mask  = (ROT_MAX_W'(1) << w) - ROT_MAX_W'(1);
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/fold_sig_compare_if.sv
// Beat input, frame result and control bundle between the fold stage and the compare block.
interface fold_sig_compare_if
  import fold_sig_pkg::*;
#(
  parameter int W = W_DEF
);

  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] aa;
  logic [W-1:0] bb;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sig_a;
  logic [W-1:0] sig_b;
  logic         match;
  logic [15:0]  mismatch_cnt;

  modport master (
    output clear, in_valid, aa, bb, out_ready,
    input  in_ready, out_valid, sig_a, sig_b, match, mismatch_cnt
  );

  modport slave (
    input  clear, in_valid, aa, bb, out_ready,
    output in_ready, out_valid, sig_a, sig_b, match, mismatch_cnt
  );

endinterface

// File: rtl/fold_sig_compare_lane.sv
// One rolling rotate-XOR signature register; clr wins over en.
module fold_sig_lane
  import fold_sig_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] word,
  output logic [W-1:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= W'(rotl1(ROT_MAX_W'(sig), W)) ^ word;
    end
  end

endmodule

// File: rtl/fold_sig_compare.sv
// Frame-based signature compare of two folded streams: ACCUM collects FRAME_LEN beats,
// HOLD presents both signatures until the result handshake completes.
module fold_sig_compare
  import fold_sig_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input logic               clk,
  input logic               rst_n,
  fold_sig_compare_if.slave bus
);

  localparam int             CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] beat_cnt_q;
  logic [15:0]      mismatch_cnt_q;
  logic [W-1:0]     sig_a;
  logic [W-1:0]     sig_b;
  logic             match;
  logic             accept;
  logic             done;
  logic             last_beat;
  logic             lane_clr;
  logic             lane_en;

  assign accept    = bus.in_valid && (state_q == ACCUM);
  assign done      = bus.out_ready && (state_q == HOLD);
  assign last_beat = (beat_cnt_q == LAST_BEAT);
  assign match     = (sig_a == sig_b);

  // A clear cycle discards any offered beat; a completed handshake restarts both signatures.
  assign lane_clr = bus.clear || done;
  assign lane_en  = accept && !bus.clear;

  fold_sig_lane #(.W(W)) u_lane_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (lane_clr),
    .en    (lane_en),
    .word  (bus.aa),
    .sig   (sig_a)
  );

  fold_sig_lane #(.W(W)) u_lane_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (lane_clr),
    .en    (lane_en),
    .word  (bus.bb),
    .sig   (sig_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (accept && last_beat) state_d = HOLD;
        HOLD:    if (bus.out_ready)       state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else if (bus.clear || done) begin
      beat_cnt_q <= '0;
    end else if (accept) begin
      beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CNT_W'(1);
    end
  end

  // Only a real handshake outside a clear cycle counts, and the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_cnt_q <= '0;
    end else if (bus.clear) begin
      mismatch_cnt_q <= '0;
    end else if (done && !match && (mismatch_cnt_q != 16'hFFFF)) begin
      mismatch_cnt_q <= mismatch_cnt_q + 16'd1;
    end
  end

  assign bus.in_ready     = (state_q == ACCUM);
  assign bus.out_valid    = (state_q == HOLD);
  assign bus.sig_a        = sig_a;
  assign bus.sig_b        = sig_b;
  assign bus.match        = match;
  assign bus.mismatch_cnt = mismatch_cnt_q;

endmodule

// File: tb/tb_fold_sig_compare.sv
// Directed bench for fold_sig_compare with FRAME_LEN = 4 and hand-computed signatures.
module tb_fold_sig_compare;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  fold_sig_compare_if #(.W(8)) bus ();

  fold_sig_compare #(.W(8), .FRAME_LEN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.aa       = a;
    bus.bb       = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic send_mismatch_frame();
    send_beat(8'h01, 8'h80);
    send_beat(8'h02, 8'h00);
    send_beat(8'h04, 8'h00);
    send_beat(8'h08, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.mismatch_cnt !== 16'h0000) $display("[TB] FAIL reset_mismatch_cnt: got %h want 0000", bus.mismatch_cnt); else passed++;
    checks++; if (bus.sig_a !== 8'h00) $display("[TB] FAIL reset_sig_a: got %h want 00", bus.sig_a); else passed++;
    checks++; if (bus.sig_b !== 8'h00) $display("[TB] FAIL reset_sig_b: got %h want 00", bus.sig_b); else passed++;
    checks++; if (bus.match !== 1'b1) $display("[TB] FAIL reset_match: got %b want 1", bus.match); else passed++;
  endtask

  task automatic test_matching_frame();
    send_beat(8'h11, 8'h11);
    send_beat(8'h22, 8'h22);
    send_beat(8'h33, 8'h33);
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL match_early_valid: got %b want 0", bus.out_valid); else passed++;
    send_beat(8'h44, 8'h44);
    checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL match_out_valid: got %b want 1", bus.out_valid); else passed++;
    checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL match_in_ready: got %b want 0", bus.in_ready); else passed++;
    checks++; if (bus.sig_a !== 8'h22) $display("[TB] FAIL match_sig_a: got %h want 22", bus.sig_a); else passed++;
    checks++; if (bus.sig_b !== 8'h22) $display("[TB] FAIL match_sig_b: got %h want 22", bus.sig_b); else passed++;
    checks++; if (bus.match !== 1'b1) $display("[TB] FAIL match_flag: got %b want 1", bus.match); else passed++;
    handshake();
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL match_post_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.sig_a !== 8'h00) $display("[TB] FAIL match_post_sig_a: got %h want 00", bus.sig_a); else passed++;
    checks++; if (bus.mismatch_cnt !== 16'h0000) $display("[TB] FAIL match_post_cnt: got %h want 0000", bus.mismatch_cnt); else passed++;
  endtask

  task automatic test_mismatch_wrap();
    send_mismatch_frame();
    checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL wrap_out_valid: got %b want 1", bus.out_valid); else passed++;
    checks++; if (bus.sig_a !== 8'h00) $display("[TB] FAIL wrap_sig_a: got %h want 00", bus.sig_a); else passed++;
    checks++; if (bus.sig_b !== 8'h04) $display("[TB] FAIL wrap_sig_b: got %h want 04", bus.sig_b); else passed++;
    checks++; if (bus.match !== 1'b0) $display("[TB] FAIL wrap_match: got %b want 0", bus.match); else passed++;
    checks++; if (bus.mismatch_cnt !== 16'h0000) $display("[TB] FAIL wrap_cnt_before: got %h want 0000", bus.mismatch_cnt); else passed++;
    handshake();
    checks++; if (bus.mismatch_cnt !== 16'h0001) $display("[TB] FAIL wrap_cnt_after: got %h want 0001", bus.mismatch_cnt); else passed++;
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL wrap_in_ready: got %b want 1", bus.in_ready); else passed++;
  endtask

  task automatic test_back_pressure();
    send_beat(8'h11, 8'h11);
    send_beat(8'h22, 8'h22);
    send_beat(8'h33, 8'h33);
    send_beat(8'h44, 8'h44);
    bus.in_valid = 1'b1;
    bus.aa       = 8'hFF;
    bus.bb       = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); else passed++;
      checks++; if (bus.sig_a !== 8'h22 || bus.sig_b !== 8'h22) $display("[TB] FAIL bp_sigs[%0d]: got %h/%h want 22/22", i, bus.sig_a, bus.sig_b); else passed++;
    end
    handshake();
    bus.in_valid = 1'b0;
    checks++; if (bus.sig_a !== 8'h00 || bus.sig_b !== 8'h00) $display("[TB] FAIL bp_after_sigs: got %h/%h want 00/00", bus.sig_a, bus.sig_b); else passed++;
    checks++; if (bus.mismatch_cnt !== 16'h0001) $display("[TB] FAIL bp_after_cnt: got %h want 0001", bus.mismatch_cnt); else passed++;
    send_beat(8'h5A, 8'h5A);
    checks++; if (bus.sig_a !== 8'h5A) $display("[TB] FAIL bp_next_first: got %h want 5a", bus.sig_a); else passed++;
    send_beat(8'h00, 8'h00);
    send_beat(8'h00, 8'h00);
    send_beat(8'h00, 8'h00);
    checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL bp_next_valid: got %b want 1", bus.out_valid); else passed++;
    checks++; if (bus.sig_a !== 8'hD2) $display("[TB] FAIL bp_next_sig: got %h want d2", bus.sig_a); else passed++;
    handshake();
  endtask

  task automatic test_gapped();
    logic [7:0] words [4];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      send_beat(words[i], words[i]);
      if (i < 3) begin
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL gap_early_valid[%0d]: got %b want 0", i, bus.out_valid); else passed++;
      end
    end
    checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL gap_out_valid: got %b want 1", bus.out_valid); else passed++;
    checks++; if (bus.sig_a !== 8'h22 || bus.sig_b !== 8'h22) $display("[TB] FAIL gap_sigs: got %h/%h want 22/22", bus.sig_a, bus.sig_b); else passed++;
    handshake();
  endtask

  task automatic test_clear();
    send_beat(8'h11, 8'h03);
    send_beat(8'h33, 8'h01);
    checks++; if (bus.sig_a !== 8'h11 || bus.sig_b !== 8'h07) $display("[TB] FAIL clr_mid_sigs: got %h/%h want 11/07", bus.sig_a, bus.sig_b); else passed++;
    bus.clear     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.aa        = 8'hFF;
    bus.bb        = 8'hFF;
    @(negedge clk);
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.sig_a !== 8'h00 || bus.sig_b !== 8'h00) $display("[TB] FAIL clr_sigs: got %h/%h want 00/00", bus.sig_a, bus.sig_b); else passed++;
    checks++; if (bus.mismatch_cnt !== 16'h0000) $display("[TB] FAIL clr_cnt: got %h want 0000", bus.mismatch_cnt); else passed++;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("[TB] FAIL clr_handshake: got %b/%b want 1/0", bus.in_ready, bus.out_valid); else passed++;
    send_beat(8'h11, 8'h11);
    send_beat(8'h22, 8'h22);
    send_beat(8'h33, 8'h33);
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL clr_early_valid: got %b want 0", bus.out_valid); else passed++;
    send_beat(8'h44, 8'h44);
    checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL clr_frame_valid: got %b want 1", bus.out_valid); else passed++;
    checks++; if (bus.sig_a !== 8'h22 || bus.sig_b !== 8'h22) $display("[TB] FAIL clr_frame_sigs: got %h/%h want 22/22", bus.sig_a, bus.sig_b); else passed++;
    handshake();
    send_mismatch_frame();
    bus.clear     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (bus.mismatch_cnt !== 16'h0000) $display("[TB] FAIL clr_hold_cnt: got %h want 0000", bus.mismatch_cnt); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL clr_hold_valid: got %b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_saturation();
    force dut.mismatch_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.mismatch_cnt_q;
    @(negedge clk);
    checks++; if (bus.mismatch_cnt !== 16'hFFFE) $display("[TB] FAIL sat_preset: got %h want fffe", bus.mismatch_cnt); else passed++;
    send_mismatch_frame();
    handshake();
    checks++; if (bus.mismatch_cnt !== 16'hFFFF) $display("[TB] FAIL sat_first: got %h want ffff", bus.mismatch_cnt); else passed++;
    send_mismatch_frame();
    checks++; if (bus.match !== 1'b0) $display("[TB] FAIL sat_match: got %b want 0", bus.match); else passed++;
    handshake();
    checks++; if (bus.mismatch_cnt !== 16'hFFFF) $display("[TB] FAIL sat_hold: got %h want ffff", bus.mismatch_cnt); else passed++;
  endtask

  initial begin
    checks        = 0;
    passed        = 0;
    rst_n         = 1'b0;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.aa        = 8'h00;
    bus.bb        = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_matching_frame();
    test_mismatch_wrap();
    test_back_pressure();
    test_gapped();
    test_clear();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fold_sig_compare.md
# fold_sig_compare

Downstream consumer of the 16-to-8-bit XOR fold stage: accepts the folded `aa`/`bb` byte pairs one beat at a time and builds a rolling rotate-XOR signature per channel over a fixed-length frame. At each frame end it presents both signatures, a match flag and a saturating mismatch count. It sits between the fold netlist and the result/status collector and lets two 16-bit data streams be checked for equivalence over a frame.

## Interface
- `W`, 8: width of folded words and signatures.
- `FRAME_LEN`, 16: beats per frame; legal range 2..65535.
- `CNT_W`, `$clog2(FRAME_LEN)`: beat counter width. Derived; do not override.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush; highest priority after reset.
- `in_valid`  in  1  `aa`/`bb` beat valid.
- `in_ready`  out  1  block can accept a beat.
- `aa`  in  W  folded word, channel A.
- `bb`  in  W  folded word, channel B.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  downstream accepts the result.
- `sig_a`  out  W  channel A frame signature.
- `sig_b`  out  W  channel B frame signature.
- `match`  out  1  `sig_a == sig_b`; meaningful only while `out_valid` is 1.
- `mismatch_cnt`  out  16  count of consumed frames with `match == 0`; saturates at 0xFFFF.

## Operation
- Per-lane update on an accepted beat (`in_valid && in_ready`): `sig <= rotl1(sig) ^ word`.
  - `rotl1` is a 1-bit left rotate: the MSB wraps to bit 0.
- FSM with two states:
  - ACCUM: `in_ready = 1`, `out_valid = 0`. Each accepted beat updates both lanes and increments `beat_cnt`. The beat accepted at `beat_cnt == FRAME_LEN-1` is folded in, then the FSM moves to HOLD.
  - HOLD: `in_ready = 0`, `out_valid = 1`. `sig_a`, `sig_b` and `match` are stable.
  - HOLD exit: when `out_valid && out_ready`:
    - clear both signatures and `beat_cnt` to 0;
    - if `match == 0`, increment `mismatch_cnt`, holding at 0xFFFF once reached;
    - return to ACCUM.
- `in_valid` low in ACCUM: no state change. Beats are never dropped or duplicated.
- In HOLD, incoming beats are back-pressured, not buffered.
- `clear`, in any state, takes effect next edge:
  - state goes to ACCUM;
  - `sig_a`, `sig_b`, `beat_cnt` and `mismatch_cnt` go to 0;
  - `out_valid` goes to 0;
  - a beat offered in the same cycle is discarded;
  - an `out_ready` handshake in the same cycle does not count toward `mismatch_cnt`.
- Reset mid-frame discards partial signatures. Frames are not resumable.

## Timing
- Reset values:
  - `in_ready = 1`, `out_valid = 0`, `match = 1`;
  - `sig_a = sig_b = 0`, `mismatch_cnt = 0`;
  - state ACCUM, `beat_cnt = 0`.
- `in_ready` and `out_valid` are registered state decodes, with no combinational path from `in_valid` or `out_ready`.
- `match` is a combinational compare of the registered signatures.
- Latency: `out_valid` rises 1 cycle after the last beat of a frame is accepted.
- Throughput: FRAME_LEN beats plus at least 1 HOLD cycle per frame.
  - Best case: `in_ready` is low for exactly 1 cycle per frame when `out_ready` is held high.
- `mismatch_cnt` updates on the edge that completes the output handshake and is visible the following cycle.

## Structure
- Package `fold_sig_pkg` holds:
  - the `state_t` enum `{ACCUM, HOLD}`;
  - the `rotl1` function, parameterised by `W`;
  - the defaults for `W` and `FRAME_LEN`.
- Sub-module `fold_sig_lane` holds one W-bit signature register and its update/clear logic. It is instantiated twice, for channels A and B.
- The top level owns the FSM, `beat_cnt`, `mismatch_cnt` and the handshakes.

## Test plan
All scenarios use `FRAME_LEN = 4`.
- Reset release with no input: `in_ready = 1`, `out_valid = 0`, `mismatch_cnt = 0`, `sig_a = sig_b = 0`.
- Matching frame: `aa = bb = 0x11, 0x22, 0x33, 0x44` on 4 consecutive cycles -> `out_valid` next cycle with `sig_a = sig_b = 0x22` and `match = 1`. After handshake, `mismatch_cnt` stays 0.
- Mismatching frame with wrap:
  - stimulus: `aa = 0x01, 0x02, 0x04, 0x08`; `bb = 0x80, 0x00, 0x00, 0x00`;
  - response: `sig_a = 0x00`, `sig_b = 0x04`, `match = 0`; after handshake, `mismatch_cnt = 1`.
- Back-pressure:
  - hold `out_ready = 0` for 5 cycles while offering beats -> `in_ready = 0` throughout, signatures stable, nothing accepted;
  - then raise `out_ready` -> one handshake, and the next frame starts from signature 0.
- Gapped input: toggle `in_valid` every cycle during the matching frame -> same result (`0x22` on both lanes) at the same beat count.
- `clear`, then saturation:
  - assert `clear` after 2 beats of a frame -> next cycle all state is zero, and a fresh 4-beat frame produces the correct signatures;
  - force `mismatch_cnt` to 0xFFFE and complete two mismatching frames -> count reads 0xFFFF and holds.
